// File: rtl/axi_regbank_pkg.sv
// Shared constants and helpers for the AXI4-Lite register bank.
// Helpers work on the widest supported data width and are cast at the call site.
package axi_regbank_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Strip the byte offset from a byte address.
   function automatic logic [63:0] reg_index(input logic [63:0] addr,
                                             input int unsigned data_width);
      return (data_width == 64) ? (addr >> 3) : (addr >> 2);
   endfunction

   // Replace only the byte lanes whose strobe bit is set.
   function automatic logic [63:0] byte_merge(input logic [63:0] old_val,
                                              input logic [63:0] new_val,
                                              input logic [7:0]  strb);
      logic [63:0] res;
      res = old_val;
      for (int b = 0; b < 8; b++) begin
         if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/axi_regbank_if.sv
// AXI4-Lite bus bundle between the PS master port and the register bank.
interface axi_regbank_if #(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 6
);
   localparam int unsigned STRB_W = C_S_AXI_DATA_WIDTH / 8;

   logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR;
   logic [2:0]                    S_AXI_AWPROT;
   logic                          S_AXI_AWVALID;
   logic                          S_AXI_AWREADY;
   logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA;
   logic [STRB_W-1:0]             S_AXI_WSTRB;
   logic                          S_AXI_WVALID;
   logic                          S_AXI_WREADY;
   logic [1:0]                    S_AXI_BRESP;
   logic                          S_AXI_BVALID;
   logic                          S_AXI_BREADY;
   logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR;
   logic [2:0]                    S_AXI_ARPROT;
   logic                          S_AXI_ARVALID;
   logic                          S_AXI_ARREADY;
   logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA;
   logic [1:0]                    S_AXI_RRESP;
   logic                          S_AXI_RVALID;
   logic                          S_AXI_RREADY;

   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      output S_AXI_RREADY,
      input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      input  S_AXI_RREADY,
      output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

endinterface

// File: rtl/axi_regbank_wrchan.sv
// Write channel: independent AW/W holding latches, commit decision and B response.
module axi_regbank_wrchan
   import axi_regbank_pkg::*;
#(
   parameter int unsigned NREGS              = 16,
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
   localparam int unsigned DW     = C_S_AXI_DATA_WIDTH,
   localparam int unsigned STRB_W = DW / 8,
   localparam int unsigned IDX_W  = C_S_AXI_ADDR_WIDTH - $clog2(STRB_W)
) (
   input  logic               clk,
   input  logic               rst,
   axi_regbank_if.slave       s_axi,
   output logic               commit,
   output logic [IDX_W-1:0]   commit_idx,
   output logic [DW-1:0]      wdata,
   output logic [STRB_W-1:0]  wstrb
);

   logic                          aw_held;
   logic                          w_held;
   logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr;
   logic [DW-1:0]                 w_data;
   logic [STRB_W-1:0]             w_strb;
   logic                          bvalid;
   logic [1:0]                    bresp;
   logic                          in_range;

   assign commit     = aw_held && w_held && !bvalid;
   assign commit_idx = IDX_W'(reg_index(64'(aw_addr), DW));
   assign wdata      = w_data;
   assign wstrb      = w_strb;
   assign in_range   = (32'(commit_idx) < NREGS);

   assign s_axi.S_AXI_AWREADY = !aw_held && !bvalid;
   assign s_axi.S_AXI_WREADY  = !w_held && !bvalid;
   assign s_axi.S_AXI_BVALID  = bvalid;
   assign s_axi.S_AXI_BRESP   = bresp;

   // Latches fill on handshake and drain together on commit; no handshake can coincide with commit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aw_held <= 1'b0;
         w_held  <= 1'b0;
         aw_addr <= '0;
         w_data  <= '0;
         w_strb  <= '0;
         bvalid  <= 1'b0;
         bresp   <= RESP_OKAY;
      end else if (commit) begin
         aw_held <= 1'b0;
         w_held  <= 1'b0;
         bvalid  <= 1'b1;
         bresp   <= in_range ? RESP_OKAY : RESP_SLVERR;
      end else begin
         if (s_axi.S_AXI_AWVALID && !aw_held && !bvalid) begin
            aw_held <= 1'b1;
            aw_addr <= s_axi.S_AXI_AWADDR;
         end
         if (s_axi.S_AXI_WVALID && !w_held && !bvalid) begin
            w_held <= 1'b1;
            w_data <= s_axi.S_AXI_WDATA;
            w_strb <= s_axi.S_AXI_WSTRB;
         end
         if (bvalid && s_axi.S_AXI_BREADY) bvalid <= 1'b0;
      end
   end

endmodule

// File: rtl/axi_regbank.sv
// Parametrised AXI4-Lite register bank with read-only, self-clearing and strobe support.
module axi_regbank
   import axi_regbank_pkg::*;
#(
   parameter int unsigned     NREGS              = 16,
   parameter int unsigned     C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned     C_S_AXI_ADDR_WIDTH = 6,
   parameter logic [NREGS-1:0] RO_MASK           = '0,
   parameter logic [NREGS-1:0] PULSE_MASK        = '0
) (
   input  logic                                 S_AXI_ACLK,
   input  logic                                 S_AXI_ARESET,
   axi_regbank_if.slave                         s_axi,
   output logic [NREGS-1:0][C_S_AXI_DATA_WIDTH-1:0] slv_reg,
   input  logic [NREGS-1:0][C_S_AXI_DATA_WIDTH-1:0] slv_read,
   output logic [NREGS-1:0]                     wr_strobe,
   output logic [NREGS-1:0]                     rd_strobe
);

   localparam int unsigned DW     = C_S_AXI_DATA_WIDTH;
   localparam int unsigned STRB_W = DW / 8;
   localparam int unsigned IDX_W  = C_S_AXI_ADDR_WIDTH - $clog2(STRB_W);
   localparam int unsigned SEL_W  = (NREGS > 1) ? $clog2(NREGS) : 1;

   logic               commit;
   logic [IDX_W-1:0]   commit_idx;
   logic [DW-1:0]      wdata;
   logic [STRB_W-1:0]  wstrb;
   logic [IDX_W-1:0]   ar_idx;
   logic               rvalid;
   logic [1:0]         rresp;
   logic [DW-1:0]      rdata;

   axi_regbank_wrchan #(
      .NREGS              (NREGS),
      .C_S_AXI_DATA_WIDTH (C_S_AXI_DATA_WIDTH),
      .C_S_AXI_ADDR_WIDTH (C_S_AXI_ADDR_WIDTH)
   ) u_wrchan (
      .clk        (S_AXI_ACLK),
      .rst        (S_AXI_ARESET),
      .s_axi      (s_axi),
      .commit     (commit),
      .commit_idx (commit_idx),
      .wdata      (wdata),
      .wstrb      (wstrb)
   );

   // Register array: committed writes merge by lane; pulse registers fall back to 0 otherwise.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         slv_reg   <= '0;
         wr_strobe <= '0;
      end else begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            if (commit && (32'(commit_idx) == i)) begin
               wr_strobe[SEL_W'(i)] <= 1'b1;
               if (!RO_MASK[SEL_W'(i)]) begin
                  slv_reg[SEL_W'(i)] <= DW'(byte_merge(64'(slv_reg[SEL_W'(i)]), 64'(wdata),
                                                       8'(wstrb)));
               end
            end else begin
               wr_strobe[SEL_W'(i)] <= 1'b0;
               if (PULSE_MASK[SEL_W'(i)]) slv_reg[SEL_W'(i)] <= '0;
            end
         end
      end
   end

   assign ar_idx = IDX_W'(reg_index(64'(s_axi.S_AXI_ARADDR), DW));

   assign s_axi.S_AXI_ARREADY = !rvalid;
   assign s_axi.S_AXI_RVALID  = rvalid;
   assign s_axi.S_AXI_RRESP   = rresp;
   assign s_axi.S_AXI_RDATA   = rdata;

   // Read channel: capture on AR handshake, hold until RREADY.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         rvalid    <= 1'b0;
         rresp     <= RESP_OKAY;
         rdata     <= '0;
         rd_strobe <= '0;
      end else begin
         rd_strobe <= '0;
         if (s_axi.S_AXI_ARVALID && !rvalid) begin
            rvalid <= 1'b1;
            rresp  <= RESP_SLVERR;
            rdata  <= '0;
            for (int unsigned i = 0; i < NREGS; i++) begin
               if (32'(ar_idx) == i) begin
                  rresp                 <= RESP_OKAY;
                  rdata                 <= slv_read[SEL_W'(i)];
                  rd_strobe[SEL_W'(i)]  <= 1'b1;
               end
            end
         end else if (rvalid && s_axi.S_AXI_RREADY) begin
            rvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axi_regbank.sv
// Self-checking bench for axi_regbank: directed scenarios plus randomized traffic
// checked against a register-level reference model.
module tb_axi_regbank;

   localparam int unsigned NREGS = 16;
   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 8;
   localparam int          TMO   = 50;

   logic clk;
   logic rst;
   logic [NREGS-1:0][DW-1:0] slv_reg;
   logic [NREGS-1:0][DW-1:0] slv_read;
   logic [NREGS-1:0]         wr_strobe;
   logic [NREGS-1:0]         rd_strobe;

   logic [NREGS-1:0][DW-1:0] model;
   int checks   = 0;
   int failures = 0;
   int wr_cnt [NREGS];
   int rd_cnt [NREGS];
   int p5_cnt   = 0;
   logic [DW-1:0] p5_last;

   axi_regbank_if #(.C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW)) bus ();

   axi_regbank #(
      .NREGS              (NREGS),
      .C_S_AXI_DATA_WIDTH (DW),
      .C_S_AXI_ADDR_WIDTH (AW),
      .RO_MASK            (16'h0001),
      .PULSE_MASK         (16'h0020)
   ) dut (
      .S_AXI_ACLK   (clk),
      .S_AXI_ARESET (rst),
      .s_axi        (bus),
      .slv_reg      (slv_reg),
      .slv_read     (slv_read),
      .wr_strobe    (wr_strobe),
      .rd_strobe    (rd_strobe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < NREGS; i++) begin wr_cnt[i] = 0; rd_cnt[i] = 0; end
      p5_last = '0;
   end

   // Strobe and pulse-register observers, sampled mid-cycle.
   always @(negedge clk) begin
      for (int i = 0; i < NREGS; i++) begin
         if (wr_strobe[i]) wr_cnt[i] = wr_cnt[i] + 1;
         if (rd_strobe[i]) rd_cnt[i] = rd_cnt[i] + 1;
      end
      if (slv_reg[5] != '0) begin p5_cnt = p5_cnt + 1; p5_last = slv_reg[5]; end
   end

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                          input logic [3:0] s);
      logic [DW-1:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
      return r;
   endfunction

   function automatic int sum_cnt(input int c [NREGS]);
      int t = 0;
      for (int i = 0; i < NREGS; i++) t += c[i];
      return t;
   endfunction

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      bit aw_done = 0, w_done = 0, hs_aw, hs_w, got = 0;
      int cyc = 0;
      bus.S_AXI_AWADDR = addr; bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = strb;
      bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_BREADY = 1'b1;
      while (!(aw_done && w_done) && cyc < TMO) begin
         hs_aw = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
         hs_w  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
         step(); cyc++;
         if (hs_aw) begin bus.S_AXI_AWVALID = 1'b0; aw_done = 1; end
         if (hs_w)  begin bus.S_AXI_WVALID  = 1'b0; w_done  = 1; end
      end
      resp = 2'b11;
      while (!got && cyc < TMO) begin
         if (bus.S_AXI_BVALID) begin resp = bus.S_AXI_BRESP; got = 1; end
         step(); cyc++;
      end
      bus.S_AXI_BREADY = 1'b0; bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
      checks++;
      if (!got) begin failures++; $display("FAIL write_timeout addr=%h got=no_bresp exp=bresp", addr); end
   endtask

   task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                           output logic [1:0] resp);
      bit hs, done = 0, got = 0;
      int cyc = 0;
      bus.S_AXI_ARADDR = addr; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b0;
      while (!done && cyc < TMO) begin
         hs = bus.S_AXI_ARREADY;
         step(); cyc++;
         if (hs) begin bus.S_AXI_ARVALID = 1'b0; done = 1; end
      end
      data = '0; resp = 2'b11;
      while (!got && cyc < TMO) begin
         if (bus.S_AXI_RVALID) begin
            data = bus.S_AXI_RDATA; resp = bus.S_AXI_RRESP; got = 1;
            bus.S_AXI_RREADY = 1'b1;
         end
         step(); cyc++;
      end
      bus.S_AXI_RREADY = 1'b0; bus.S_AXI_ARVALID = 1'b0;
      checks++;
      if (!got) begin failures++; $display("FAIL read_timeout addr=%h got=no_rvalid exp=rvalid", addr); end
   endtask

   task automatic test_reset();
      checks++;
      if ({bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_BRESP, bus.S_AXI_RRESP} !== 6'b0) begin
         failures++; $display("FAIL reset_valid_resp got=%b exp=000000",
                              {bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_BRESP, bus.S_AXI_RRESP});
      end
      checks++;
      if (bus.S_AXI_RDATA !== '0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", bus.S_AXI_RDATA); end
      checks++;
      if (slv_reg !== model) begin failures++; $display("FAIL reset_slv_reg got=%h exp=%h", slv_reg, model); end
      checks++;
      if ({wr_strobe, rd_strobe} !== '0) begin
         failures++; $display("FAIL reset_strobes got=%h exp=0", {wr_strobe, rd_strobe});
      end
      checks++;
      if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b111) begin
         failures++; $display("FAIL reset_ready got=%b exp=111",
                              {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY});
      end
   endtask

   // AW and W together: commit and BVALID one edge later, strobe for one cycle.
   task automatic test_write_basic();
      bus.S_AXI_AWADDR = 8'h0C; bus.S_AXI_WDATA = 32'hA5A5_1234; bus.S_AXI_WSTRB = 4'hF;
      bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_BREADY = 1'b0;
      step();
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
      checks++;
      if (bus.S_AXI_BVALID !== 1'b0) begin failures++; $display("FAIL wr_bvalid_e0 got=%b exp=0", bus.S_AXI_BVALID); end
      step();
      model[3] = merge(model[3], 32'hA5A5_1234, 4'hF);
      checks++;
      if ({bus.S_AXI_BVALID, bus.S_AXI_BRESP} !== 3'b100) begin
         failures++; $display("FAIL wr_bresp_e1 got=%b exp=100", {bus.S_AXI_BVALID, bus.S_AXI_BRESP});
      end
      checks++;
      if (slv_reg[3] !== model[3]) begin failures++; $display("FAIL wr_reg3 got=%h exp=%h", slv_reg[3], model[3]); end
      checks++;
      if (wr_strobe !== 16'h0008) begin failures++; $display("FAIL wr_strobe_e1 got=%h exp=0008", wr_strobe); end
      step();
      checks++;
      if (wr_strobe !== 16'h0000) begin failures++; $display("FAIL wr_strobe_e2 got=%h exp=0000", wr_strobe); end
      checks++;
      if (bus.S_AXI_BVALID !== 1'b1) begin failures++; $display("FAIL wr_bvalid_hold got=%b exp=1", bus.S_AXI_BVALID); end
      bus.S_AXI_BREADY = 1'b1; step(); bus.S_AXI_BREADY = 1'b0;
      checks++;
      if (bus.S_AXI_BVALID !== 1'b0) begin failures++; $display("FAIL wr_bvalid_clr got=%b exp=0", bus.S_AXI_BVALID); end
   endtask

   // W two cycles ahead of AW, single byte lane, B held off.
   task automatic test_w_before_aw();
      bus.S_AXI_WDATA = 32'h0000_BB00; bus.S_AXI_WSTRB = 4'h2; bus.S_AXI_WVALID = 1'b1;
      step();
      bus.S_AXI_WVALID = 1'b0;
      checks++;
      if (bus.S_AXI_WREADY !== 1'b0) begin failures++; $display("FAIL wfirst_wready got=%b exp=0", bus.S_AXI_WREADY); end
      step();
      bus.S_AXI_AWADDR = 8'h0C; bus.S_AXI_AWVALID = 1'b1;
      step();
      bus.S_AXI_AWVALID = 1'b0;
      checks++;
      if (bus.S_AXI_BVALID !== 1'b0) begin failures++; $display("FAIL wfirst_bvalid_early got=%b exp=0", bus.S_AXI_BVALID); end
      step();
      model[3] = merge(model[3], 32'h0000_BB00, 4'h2);
      checks++;
      if (slv_reg[3] !== 32'hA5A5_BB34 || slv_reg[3] !== model[3]) begin
         failures++; $display("FAIL wfirst_reg3 got=%h exp=%h", slv_reg[3], model[3]);
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({bus.S_AXI_BVALID, bus.S_AXI_AWREADY} !== 2'b10) begin
            failures++; $display("FAIL wfirst_awready_blocked got=%b exp=10", {bus.S_AXI_BVALID, bus.S_AXI_AWREADY});
         end
         step();
      end
      bus.S_AXI_BREADY = 1'b1; step(); bus.S_AXI_BREADY = 1'b0;
      checks++;
      if (bus.S_AXI_AWREADY !== 1'b1) begin failures++; $display("FAIL wfirst_awready_back got=%b exp=1", bus.S_AXI_AWREADY); end
   endtask

   task automatic test_out_of_range();
      logic [1:0] resp; logic [DW-1:0] d; int w0, r0;
      w0 = sum_cnt(wr_cnt); r0 = sum_cnt(rd_cnt);
      axi_write(8'h40, 32'h1234_5678, 4'hF, resp);
      checks++;
      if (resp !== 2'b10) begin failures++; $display("FAIL oor_bresp got=%b exp=10", resp); end
      checks++;
      if (slv_reg !== model) begin failures++; $display("FAIL oor_regs got=%h exp=%h", slv_reg, model); end
      axi_read(8'h40, d, resp);
      checks++;
      if ({resp, d} !== {2'b10, 32'h0}) begin failures++; $display("FAIL oor_read got=%b/%h exp=10/0", resp, d); end
      checks++;
      if (sum_cnt(wr_cnt) != w0 || sum_cnt(rd_cnt) != r0) begin
         failures++; $display("FAIL oor_strobes got=%0d/%0d exp=%0d/%0d", sum_cnt(wr_cnt), sum_cnt(rd_cnt), w0, r0);
      end
   endtask

   task automatic test_pulse();
      logic [1:0] resp; int c0;
      c0 = p5_cnt;
      axi_write(8'h14, 32'h0000_0001, 4'hF, resp);
      checks++;
      if (p5_cnt - c0 != 1 || p5_last !== 32'h1) begin
         failures++; $display("FAIL pulse_once got=%0d cyc val=%h exp=1 cyc val=1", p5_cnt - c0, p5_last);
      end
      checks++;
      if (slv_reg[5] !== 32'h0) begin failures++; $display("FAIL pulse_clear got=%h exp=0", slv_reg[5]); end
      axi_write(8'h14, 32'h0000_0007, 4'hF, resp);
      checks++;
      if (p5_cnt - c0 != 2 || p5_last !== 32'h7 || resp !== 2'b00) begin
         failures++; $display("FAIL pulse_repulse got=%0d cyc val=%h exp=2 cyc val=7", p5_cnt - c0, p5_last);
      end
   endtask

   task automatic test_read_only();
      logic [1:0] resp; logic [DW-1:0] d; int w0, r0;
      slv_read[0] = 32'hDEAD_BEEF;
      w0 = wr_cnt[0]; r0 = rd_cnt[0];
      axi_write(8'h00, 32'h0000_0000, 4'hF, resp);
      axi_write(8'h01, 32'hFFFF_FFFF, 4'hF, resp);
      checks++;
      if (resp !== 2'b00 || slv_reg[0] !== 32'h0) begin
         failures++; $display("FAIL ro_write got=%b/%h exp=00/0", resp, slv_reg[0]);
      end
      checks++;
      if (wr_cnt[0] - w0 != 2) begin failures++; $display("FAIL ro_wr_strobe got=%0d exp=2", wr_cnt[0] - w0); end
      axi_read(8'h00, d, resp);
      checks++;
      if ({resp, d} !== {2'b00, 32'hDEAD_BEEF}) begin failures++; $display("FAIL ro_read got=%b/%h exp=00/deadbeef", resp, d); end
      checks++;
      if (rd_cnt[0] - r0 != 1) begin failures++; $display("FAIL ro_rd_strobe got=%0d exp=1", rd_cnt[0] - r0); end
   endtask

   // Randomized mixed traffic, including out-of-range indices and odd byte offsets.
   task automatic test_random();
      logic [1:0] resp; logic [DW-1:0] d, data; logic [3:0] strb; logic [AW-1:0] addr;
      int idx, w0, r0;
      for (int n = 0; n < 40; n++) begin
         idx  = int'($urandom_range(0, NREGS + 1));
         addr = AW'(idx * 4 + int'($urandom_range(0, 3)));
         data = $urandom;
         strb = 4'($urandom);
         if ($urandom_range(0, 1) == 0) begin
            w0 = sum_cnt(wr_cnt);
            axi_write(addr, data, strb, resp);
            if (idx < NREGS && idx != 0 && idx != 5) model[idx] = merge(model[idx], data, strb);
            checks++;
            if (resp !== ((idx < NREGS) ? 2'b00 : 2'b10)) begin
               failures++; $display("FAIL rnd_bresp idx=%0d got=%b exp=%b", idx, resp, (idx < NREGS) ? 2'b00 : 2'b10);
            end
            checks++;
            if (slv_reg !== model) begin failures++; $display("FAIL rnd_regs idx=%0d got=%h exp=%h", idx, slv_reg, model); end
            checks++;
            if (sum_cnt(wr_cnt) - w0 != ((idx < NREGS) ? 1 : 0)) begin
               failures++; $display("FAIL rnd_wr_strobe idx=%0d got=%0d", idx, sum_cnt(wr_cnt) - w0);
            end
         end else begin
            for (int i = 0; i < NREGS; i++) slv_read[i] = $urandom;
            r0 = sum_cnt(rd_cnt);
            axi_read(addr, d, resp);
            checks++;
            if (idx < NREGS) begin
               if ({resp, d} !== {2'b00, slv_read[idx]}) begin
                  failures++; $display("FAIL rnd_read idx=%0d got=%b/%h exp=00/%h", idx, resp, d, slv_read[idx]);
               end
            end else if ({resp, d} !== {2'b10, 32'h0}) begin
               failures++; $display("FAIL rnd_read_oor idx=%0d got=%b/%h exp=10/0", idx, resp, d);
            end
            checks++;
            if (sum_cnt(rd_cnt) - r0 != ((idx < NREGS) ? 1 : 0)) begin
               failures++; $display("FAIL rnd_rd_strobe idx=%0d got=%0d", idx, sum_cnt(rd_cnt) - r0);
            end
         end
      end
   endtask

   task automatic test_reset_midflight();
      logic [1:0] resp;
      bus.S_AXI_AWADDR = 8'h08; bus.S_AXI_WDATA = 32'h0BAD_F00D; bus.S_AXI_WSTRB = 4'hF;
      bus.S_AXI_ARADDR = 8'h08;
      bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
      bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
      step();
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
      step();
      checks++;
      if ({bus.S_AXI_BVALID, bus.S_AXI_RVALID} !== 2'b11 || slv_reg[2] !== 32'h0BAD_F00D) begin
         failures++; $display("FAIL rst_setup got=%b/%h exp=11/0badf00d", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, slv_reg[2]);
      end
      #2 rst = 1'b1;
      #1;
      model = '0;
      checks++;
      if ({bus.S_AXI_BVALID, bus.S_AXI_RVALID} !== 2'b00) begin
         failures++; $display("FAIL rst_async_valid got=%b exp=00", {bus.S_AXI_BVALID, bus.S_AXI_RVALID});
      end
      checks++;
      if (slv_reg !== model) begin failures++; $display("FAIL rst_async_regs got=%h exp=0", slv_reg); end
      step(); step();
      rst = 1'b0;
      step();
      checks++;
      if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b111) begin
         failures++; $display("FAIL rst_ready got=%b exp=111", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY});
      end
      axi_write(8'h1C, 32'h5566_7788, 4'hF, resp);
      model[7] = 32'h5566_7788;
      checks++;
      if (resp !== 2'b00 || slv_reg !== model) begin
         failures++; $display("FAIL rst_after_write got=%b/%h exp=00/%h", resp, slv_reg, model);
      end
   endtask

   initial begin
      rst = 1'b1;
      model = '0;
      slv_read = '0;
      bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 1'b0;
      bus.S_AXI_BREADY = 1'b0;
      bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
      bus.S_AXI_RREADY = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      step();
      test_reset();
      test_write_basic();
      test_w_before_aw();
      test_out_of_range();
      test_pulse();
      test_read_only();
      test_random();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
